layer3_conv_sequencer: RTL and testbench
========================================

// Module: layer3_conv_sequencer
// PURPOSE
// - Sequences the layer-3 5x5 convolution datapath (8 input channels x 16 output channels) over one feature map.
// - Generates feature-RAM and weight-ROM tap addresses, the datapath start pulse and per-pixel output handshakes.
// - Sits between the layer-2 feature buffer and the layer-3 conv array; downstream is the pooling stage.
// PARAMETERS
// - IN_W        12  input map width (pixels)
// - IN_H        12  input map height (pixels)
// - FILTER_W     5  kernel side; taps per pixel = FILTER_W*FILTER_W = 25
// - RD_LAT       1  feature-RAM read latency (cycles); conv_start is delayed by RD_LAT
// - ADDR_W       8  feature-RAM address width; must satisfy 2**ADDR_W >= IN_W*IN_H
// PORTS
// - clk_in      in   1       clock, all logic on rising edge
// - rst         in   1       asynchronous reset, active-high
// - frame_start in   1       one-cycle pulse: begin a new map (IDLE only)
// - busy        out  1       high from frame_start accept until done
// - done        out  1       one-cycle pulse after last pixel handshake
// - feat_rd_en  out  1       feature-RAM read strobe
// - feat_addr   out  ADDR_W  feature-RAM address = (y+ky)*IN_W + (x+kx)
// - wgt_addr    out  5       weight-ROM tap index ky*FILTER_W+kx, 0..24
// - conv_start  out  1       datapath start, pulse aligned to tap-0 data
// - conv_ready  in   1       datapath result valid (level or pulse)
// - out_valid   out  1       current pixel result available
// - out_ready   in   1       downstream accepts when out_valid & out_ready
// - out_x       out  4       output column of current result
// - out_y       out  4       output row of current result
// BEHAVIOUR
// - Output map OUT_W = IN_W-FILTER_W+1, OUT_H = IN_H-FILTER_W+1 (8x8 at defaults), raster order x fastest.
// - Reset: state IDLE; busy, done, feat_rd_en, conv_start, out_valid = 0; feat_addr, wgt_addr, out_x, out_y = 0.
// - FSM IDLE -> TAPS -> WAIT -> EMIT -> (TAPS next pixel | DONE -> IDLE).
// - IDLE: frame_start=1 -> TAPS, busy=1 next cycle, pixel (0,0). frame_start outside IDLE ignored.
// - TAPS: 25 consecutive cycles, feat_rd_en=1, kx fastest then ky; wgt_addr = tap index.
// - conv_start = tap-0 read strobe delayed RD_LAT cycles (exactly one pulse per pixel).
// - WAIT: feat_rd_en=0; leave on first cycle conv_ready=1 sampled after last tap issued; conv_ready during TAPS ignored.
// - EMIT: out_valid=1, out_x/out_y stable until out_valid&out_ready; out_ready already high -> valid lasts 1 cycle.
// - Pixel advance on handshake: x+1; x wraps OUT_W-1 -> 0 with y+1. Last pixel (OUT_W-1,OUT_H-1) -> DONE.
// - DONE: done=1 one cycle, busy drops same edge, -> IDLE; frame_start in DONE cycle ignored.
// - Address arithmetic unsigned, computed from counters (no accumulation drift); no address exceeds IN_W*IN_H-1.
// - rst asserted mid-frame: immediate return to reset values; no done pulse; partial pixel discarded.
// CONFIGURATION
// - LAYER3_SEQ_PERF_EN defined: adds out perf_cycles[31:0] (cycles busy) and perf_stall[31:0] (cycles EMIT with out_ready=0).
//   Both clear on accepted frame_start, hold after done, reset to 0.
// - Not defined: no perf ports, no counters; behaviour otherwise identical.
// STRUCTURE
// - Shared package/include: FSM state encodings (IDLE,TAPS,WAIT,EMIT,DONE), TAPS_PER_PIX=25, OUT_W/OUT_H derivation.
// - One sub-module: layer3_tap_addr_gen (kx/ky counters + feat_addr/wgt_addr generation, last_tap flag).
// - Top: FSM, pixel x/y counters, RD_LAT delay line for conv_start, optional perf counters.
// TESTING
// - Reset then frame_start -> busy=1; pixel (0,0) feat_addr 0,1,2,3,4,12,...,52; wgt_addr 0..24; conv_start 1 cycle after tap 0.
// - Model conv_ready 3 cycles after last tap, out_ready tied 1 -> 64 pixels, raster order, done pulse after (7,7); pixel (7,7) addr 91..143.
// - out_ready low 5 cycles in EMIT of pixel (3,2) -> out_valid, out_x=3, out_y=2 held; advance only on handshake.
// - conv_ready=1 throughout TAPS -> ignored; WAIT exits first post-tap cycle; exactly one conv_start per pixel.
// - rst pulse during pixel (4,5) TAPS -> all outputs reset values; next frame_start restarts at (0,0), addr 0.
// - LAYER3_SEQ_PERF_EN, 5-cycle stall above -> perf_stall=5; frame_start while busy -> no restart, counters unchanged.

Source files
------------

// File: rtl/layer3_conv_sequencer_pkg.sv
// Shared definitions for the layer-3 convolution sequencer: geometry,
// derived output-map size and FSM state encodings.
package layer3_conv_sequencer_pkg;

  localparam int IN_W         = 12;
  localparam int IN_H         = 12;
  localparam int FILTER_W     = 5;
  localparam int RD_LAT       = 1;
  localparam int ADDR_W       = 8;

  localparam int TAPS_PER_PIX = FILTER_W * FILTER_W;
  localparam int OUT_W        = IN_W - FILTER_W + 1;
  localparam int OUT_H        = IN_H - FILTER_W + 1;

  localparam int K_W          = $clog2(FILTER_W);
  localparam int WGT_W        = 5;
  localparam int PIX_W        = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_TAPS = 3'd1,
    ST_WAIT = 3'd2,
    ST_EMIT = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Weight-ROM tap index for kernel position (ky, kx), kx fastest
  function automatic logic [WGT_W-1:0] tap_index(input logic [K_W-1:0] ky,
                                                 input logic [K_W-1:0] kx);
    return WGT_W'(ky) * WGT_W'(FILTER_W) + WGT_W'(kx);
  endfunction

endpackage

// File: rtl/layer3_tap_addr_gen.sv
// Kernel tap walker: kx/ky counters, feature-RAM and weight-ROM address
// generation for the current output pixel, and the last-tap flag.
// Addresses are recomputed from the counters every cycle, so nothing drifts.
module layer3_tap_addr_gen
  import layer3_conv_sequencer_pkg::*;
(
  input  logic              i_clk_in,
  input  logic              i_rst,
  input  logic              i_clear,
  input  logic              i_step,
  input  logic [PIX_W-1:0]  i_pix_x,
  input  logic [PIX_W-1:0]  i_pix_y,
  output logic [ADDR_W-1:0] o_feat_addr,
  output logic [WGT_W-1:0]  o_wgt_addr,
  output logic              o_last_tap
);

  localparam logic [K_W-1:0] K_LAST = K_W'(FILTER_W - 1);

  logic [K_W-1:0]    r_kx;
  logic [K_W-1:0]    r_ky;
  logic [ADDR_W-1:0] w_row;
  logic [ADDR_W-1:0] w_col;

  // Step through the kernel, kx fastest, wrapping back to (0,0) after the last tap
  always_ff @(posedge i_clk_in or posedge i_rst) begin
    if (i_rst) begin
      r_kx <= '0;
      r_ky <= '0;
    end else if (i_clear) begin
      r_kx <= '0;
      r_ky <= '0;
    end else if (i_step) begin
      if (r_kx == K_LAST) begin
        r_kx <= '0;
        r_ky <= (r_ky == K_LAST) ? '0 : r_ky + K_W'(1);
      end else begin
        r_kx <= r_kx + K_W'(1);
      end
    end
  end

  assign w_row       = ADDR_W'(i_pix_y) + ADDR_W'(r_ky);
  assign w_col       = ADDR_W'(i_pix_x) + ADDR_W'(r_kx);
  assign o_feat_addr = w_row * ADDR_W'(IN_W) + w_col;
  assign o_wgt_addr  = tap_index(r_ky, r_kx);
  assign o_last_tap  = (r_kx == K_LAST) && (r_ky == K_LAST);

endmodule

// File: rtl/layer3_conv_sequencer.sv
// Layer-3 5x5 convolution sequencer: walks the output map in raster order,
// issues 25 feature/weight tap reads per pixel, waits for the datapath and
// hands each result downstream with a valid/ready handshake.
// Optional build macro LAYER3_SEQ_PERF_EN adds busy-cycle and output-stall
// counters on o_perf_cycles / o_perf_stall.
module layer3_conv_sequencer
  import layer3_conv_sequencer_pkg::*;
(
  input  logic              i_clk_in,
  input  logic              i_rst,
  input  logic              i_frame_start,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_feat_rd_en,
  output logic [ADDR_W-1:0] o_feat_addr,
  output logic [WGT_W-1:0]  o_wgt_addr,
  output logic              o_conv_start,
  input  logic              i_conv_ready,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [PIX_W-1:0]  o_out_x,
  output logic [PIX_W-1:0]  o_out_y
`ifdef LAYER3_SEQ_PERF_EN
  ,
  output logic [31:0]       o_perf_cycles,
  output logic [31:0]       o_perf_stall
`endif
);

  localparam logic [PIX_W-1:0] X_LAST = PIX_W'(OUT_W - 1);
  localparam logic [PIX_W-1:0] Y_LAST = PIX_W'(OUT_H - 1);

  state_t              r_state;
  state_t              w_state_next;
  logic [PIX_W-1:0]    r_pix_x;
  logic [PIX_W-1:0]    r_pix_y;
  logic [RD_LAT-1:0]   r_start_dly;
  logic                w_frame_accept;
  logic                w_handshake;
  logic                w_last_pix;
  logic                w_last_tap;
  logic                w_tap0;

  assign w_frame_accept = (r_state == ST_IDLE) && i_frame_start;
  assign w_handshake    = (r_state == ST_EMIT) && i_out_ready;
  assign w_last_pix     = (r_pix_x == X_LAST) && (r_pix_y == Y_LAST);
  assign w_tap0         = (r_state == ST_TAPS) && (o_wgt_addr == '0);

  layer3_tap_addr_gen u_tap_addr_gen (
    .i_clk_in    (i_clk_in),
    .i_rst       (i_rst),
    .i_clear     (w_frame_accept),
    .i_step      (r_state == ST_TAPS),
    .i_pix_x     (r_pix_x),
    .i_pix_y     (r_pix_y),
    .o_feat_addr (o_feat_addr),
    .o_wgt_addr  (o_wgt_addr),
    .o_last_tap  (w_last_tap)
  );

  // FSM state register
  always_ff @(posedge i_clk_in or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // FSM next-state: conv_ready only counts once the last tap has been issued
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (i_frame_start) w_state_next = ST_TAPS;
      ST_TAPS: if (w_last_tap)    w_state_next = ST_WAIT;
      ST_WAIT: if (i_conv_ready)  w_state_next = ST_EMIT;
      ST_EMIT: if (i_out_ready)   w_state_next = w_last_pix ? ST_DONE : ST_TAPS;
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // FSM outputs decoded from the current state
  always_comb begin
    o_busy       = 1'b0;
    o_done       = 1'b0;
    o_feat_rd_en = 1'b0;
    o_out_valid  = 1'b0;
    case (r_state)
      ST_TAPS: begin
        o_busy       = 1'b1;
        o_feat_rd_en = 1'b1;
      end
      ST_WAIT: o_busy = 1'b1;
      ST_EMIT: begin
        o_busy      = 1'b1;
        o_out_valid = 1'b1;
      end
      ST_DONE: o_done = 1'b1;
      default: ;
    endcase
  end

  // Output-pixel raster counters, advanced only on an accepted result
  always_ff @(posedge i_clk_in or posedge i_rst) begin
    if (i_rst) begin
      r_pix_x <= '0;
      r_pix_y <= '0;
    end else if (w_frame_accept) begin
      r_pix_x <= '0;
      r_pix_y <= '0;
    end else if (w_handshake) begin
      if (r_pix_x == X_LAST) begin
        r_pix_x <= '0;
        r_pix_y <= (r_pix_y == Y_LAST) ? '0 : r_pix_y + PIX_W'(1);
      end else begin
        r_pix_x <= r_pix_x + PIX_W'(1);
      end
    end
  end

  assign o_out_x = r_pix_x;
  assign o_out_y = r_pix_y;

  // Delay the tap-0 strobe by the feature-RAM latency so conv_start meets tap-0 data
  always_ff @(posedge i_clk_in or posedge i_rst) begin
    if (i_rst) begin
      r_start_dly <= '0;
    end else begin
      r_start_dly[0] <= w_tap0;
      for (int i = 1; i < RD_LAT; i++) r_start_dly[i] <= r_start_dly[i-1];
    end
  end

  assign o_conv_start = r_start_dly[RD_LAT-1];

`ifdef LAYER3_SEQ_PERF_EN
  logic [31:0] r_perf_cycles;
  logic [31:0] r_perf_stall;

  // Busy and downstream-stall cycle counters; cleared when a frame is accepted
  always_ff @(posedge i_clk_in or posedge i_rst) begin
    if (i_rst) begin
      r_perf_cycles <= '0;
      r_perf_stall  <= '0;
    end else if (w_frame_accept) begin
      r_perf_cycles <= '0;
      r_perf_stall  <= '0;
    end else begin
      if (o_busy) r_perf_cycles <= r_perf_cycles + 32'd1;
      if ((r_state == ST_EMIT) && !i_out_ready) r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign o_perf_cycles = r_perf_cycles;
  assign o_perf_stall  = r_perf_stall;
`endif

endmodule

// File: tb/tb_layer3_conv_sequencer.sv
// Directed testbench for layer3_conv_sequencer (12x12 input, 5x5 kernel,
// 8x8 output). Perf counter checks are active when LAYER3_SEQ_PERF_EN is defined.
module tb_layer3_conv_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_start;
  logic       busy, done, feat_rd_en, conv_start, out_valid;
  logic [7:0] feat_addr;
  logic [4:0] wgt_addr;
  logic       conv_ready;
  logic       out_ready;
  logic [3:0] out_x, out_y;
`ifdef LAYER3_SEQ_PERF_EN
  logic [31:0] perf_cycles, perf_stall;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  layer3_conv_sequencer dut (
    .i_clk_in      (clk),
    .i_rst         (rst),
    .i_frame_start (frame_start),
    .o_busy        (busy),
    .o_done        (done),
    .o_feat_rd_en  (feat_rd_en),
    .o_feat_addr   (feat_addr),
    .o_wgt_addr    (wgt_addr),
    .o_conv_start  (conv_start),
    .i_conv_ready  (conv_ready),
    .o_out_valid   (out_valid),
    .i_out_ready   (out_ready),
    .o_out_x       (out_x),
    .o_out_y       (out_y)
`ifdef LAYER3_SEQ_PERF_EN
    ,
    .o_perf_cycles (perf_cycles),
    .o_perf_stall  (perf_stall)
`endif
  );

  // One output pixel starting at the cycle after TAPS is entered.
  // rdy_delay: WAIT cycles before conv_ready is sampled high; stall: extra EMIT cycles with out_ready low.
  task automatic run_pixel(input int px, input int py, input int rdy_delay, input int stall,
                           input bit rdy_in_taps, input int fs_tap);
    int starts;
    int exp_addr;
    starts = 0;
    for (int t = 0; t < 25; t++) begin
      @(negedge clk);
      exp_addr = (py + t / 5) * 12 + px + t % 5;
      n_tests++;
      if (feat_rd_en !== 1'b1 || wgt_addr !== 5'(t) || feat_addr !== 8'(exp_addr) ||
          busy !== 1'b1 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL tap (%0d,%0d) t=%0d: rd_en=%b wgt=%0d addr=%0d busy=%b valid=%b, required 1/%0d/%0d/1/0",
                 px, py, t, feat_rd_en, wgt_addr, feat_addr, busy, out_valid, t, exp_addr);
      end
      if (conv_start === 1'b1) starts++;
      n_tests++;
      if (conv_start !== (t == 1)) begin
        n_fail++;
        $display("FAIL conv_start (%0d,%0d) t=%0d: got %b, required %b", px, py, t, conv_start, (t == 1));
      end
      conv_ready  = rdy_in_taps;
      frame_start = (t == fs_tap);
    end
    for (int w = 1; w <= rdy_delay; w++) begin
      @(negedge clk);
      frame_start = 1'b0;
      if (conv_start === 1'b1) starts++;
      n_tests++;
      if (feat_rd_en !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL wait (%0d,%0d) w=%0d: rd_en=%b valid=%b busy=%b, required 0/0/1",
                 px, py, w, feat_rd_en, out_valid, busy);
      end
      conv_ready = (w == rdy_delay) || rdy_in_taps;
    end
    @(negedge clk);
    conv_ready = 1'b0;
    if (conv_start === 1'b1) starts++;
    n_tests++;
    if (out_valid !== 1'b1 || out_x !== 4'(px) || out_y !== 4'(py) || feat_rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL emit (%0d,%0d): valid=%b x=%0d y=%0d rd_en=%b, required 1/%0d/%0d/0",
               px, py, out_valid, out_x, out_y, feat_rd_en, px, py);
    end
    out_ready = (stall == 0);
    for (int s = 1; s <= stall; s++) begin
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b1 || out_x !== 4'(px) || out_y !== 4'(py)) begin
        n_fail++;
        $display("FAIL stall hold (%0d,%0d) s=%0d: valid=%b x=%0d y=%0d, required 1/%0d/%0d",
                 px, py, s, out_valid, out_x, out_y, px, py);
      end
      if (s == stall) out_ready = 1'b1;
    end
    n_tests++;
    if (starts != 1) begin
      n_fail++;
      $display("FAIL conv_start count (%0d,%0d): got %0d, required 1", px, py, starts);
    end
    $display("[TB] pixel (%0d,%0d) handshake", px, py);
  endtask

  // Full 8x8 frame, then checks the done pulse and that a frame_start in the DONE cycle is ignored
  task automatic run_frame(input int stall_px, input int rdy_delay, input bit rdy_in_taps, input int fs_px);
    @(negedge clk);
    frame_start = 1'b1;
    for (int p = 0; p < 64; p++)
      run_pixel(p % 8, p / 8, rdy_delay, (p == stall_px) ? 5 : 0, rdy_in_taps, (p == fs_px) ? 10 : -1);
    @(negedge clk);
    n_tests++;
    if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL done pulse: done=%b busy=%b valid=%b, required 1/0/0", done, busy, out_valid);
    end
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    @(negedge clk);
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b0 || feat_rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL after done: done=%b busy=%b rd_en=%b, required 0/0/0", done, busy, feat_rd_en);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || feat_rd_en !== 1'b0 || conv_start !== 1'b0 || out_valid !== 1'b0 ||
        feat_addr !== 8'd0 || wgt_addr !== 5'd0 || out_x !== 4'd0 || out_y !== 4'd0) begin
      n_fail++;
      $display("FAIL reset values: busy=%b done=%b rd_en=%b start=%b valid=%b addr=%0d wgt=%0d x=%0d y=%0d, required all 0",
               busy, done, feat_rd_en, conv_start, out_valid, feat_addr, wgt_addr, out_x, out_y);
    end
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || feat_rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL idle after reset: busy=%b rd_en=%b, required 0/0", busy, feat_rd_en);
    end
    $display("[TB] reset checked");
  endtask

  task automatic test_full_frame();
    run_frame(-1, 3, 1'b0, -1);
`ifdef LAYER3_SEQ_PERF_EN
    n_tests++;
    if (perf_cycles !== 32'd1856 || perf_stall !== 32'd0) begin
      n_fail++;
      $display("FAIL perf full frame: cycles=%0d stall=%0d, required 1856/0", perf_cycles, perf_stall);
    end
`endif
    $display("[TB] full frame checked");
  endtask

  task automatic test_stall();
    // pixel (3,2) is index 19; frame_start pulsed mid-pixel (1,0) must be ignored
    run_frame(19, 3, 1'b0, 1);
`ifdef LAYER3_SEQ_PERF_EN
    n_tests++;
    if (perf_stall !== 32'd5 || perf_cycles !== 32'd1861) begin
      n_fail++;
      $display("FAIL perf stall frame: cycles=%0d stall=%0d, required 1861/5", perf_cycles, perf_stall);
    end
`endif
    $display("[TB] stall frame checked");
  endtask

  task automatic test_ready_in_taps();
    run_frame(-1, 1, 1'b1, -1);
    $display("[TB] conv_ready-during-taps frame checked");
  endtask

  task automatic test_reset_mid();
    int exp_addr;
    @(negedge clk);
    frame_start = 1'b1;
    for (int p = 0; p < 44; p++) run_pixel(p % 8, p / 8, 1, 0, 1'b0, -1);
    for (int t = 0; t < 7; t++) begin
      @(negedge clk);
      exp_addr = (5 + t / 5) * 12 + 4 + t % 5;
      n_tests++;
      if (feat_rd_en !== 1'b1 || feat_addr !== 8'(exp_addr) || out_x !== 4'd4 || out_y !== 4'd5) begin
        n_fail++;
        $display("FAIL pre-reset tap t=%0d: rd_en=%b addr=%0d x=%0d y=%0d, required 1/%0d/4/5",
                 t, feat_rd_en, feat_addr, out_x, out_y, exp_addr);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || feat_rd_en !== 1'b0 || conv_start !== 1'b0 || out_valid !== 1'b0 ||
        feat_addr !== 8'd0 || wgt_addr !== 5'd0 || out_x !== 4'd0 || out_y !== 4'd0) begin
      n_fail++;
      $display("FAIL mid-frame reset: busy=%b done=%b rd_en=%b start=%b valid=%b addr=%0d wgt=%0d x=%0d y=%0d, required all 0",
               busy, done, feat_rd_en, conv_start, out_valid, feat_addr, wgt_addr, out_x, out_y);
    end
`ifdef LAYER3_SEQ_PERF_EN
    n_tests++;
    if (perf_cycles !== 32'd0 || perf_stall !== 32'd0) begin
      n_fail++;
      $display("FAIL perf after reset: cycles=%0d stall=%0d, required 0/0", perf_cycles, perf_stall);
    end
`endif
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL idle after mid reset: busy=%b done=%b, required 0/0", busy, done);
    end
    frame_start = 1'b1;
    run_pixel(0, 0, 1, 0, 1'b0, -1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    $display("[TB] mid-frame reset checked");
  endtask

  initial begin
    rst         = 1'b1;
    frame_start = 1'b0;
    conv_ready  = 1'b0;
    out_ready   = 1'b1;
    test_reset();
    test_full_frame();
    test_stall();
    test_ready_in_taps();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
